// File: rtl/pool_fmap_buffer_pkg.sv
// Shared definitions for the pooled feature-map buffer and the conv layers.
// Holds the default geometry (BW, CH, FM_SIZE), the buffer FSM encoding and
// an index-width helper that stays >= 1 for degenerate sizes.
package pool_fmap_buffer_pkg;

  localparam int unsigned DEF_BW      = 16;
  localparam int unsigned DEF_CH      = 3;
  localparam int unsigned DEF_FM_SIZE = 12;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } fmap_state_e;

  // Width of an index into n entries, never below 1 bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// Single-write / single-read synchronous RAM, BW x DEPTH.
// Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata is
// registered (1-cycle latency) and holds its value while re is low.
module fmap_ram
  import pool_fmap_buffer_pkg::*;
#(
  parameter int unsigned BW    = DEF_BW,
  parameter int unsigned DEPTH = DEF_FM_SIZE * DEF_FM_SIZE,
  localparam int unsigned AW   = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [BW-1:0] rdata
);

  logic [BW-1:0] mem [DEPTH];

  // Read data is held while re is low; the top relies on this as its
  // in-flight word slot under backpressure.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pool_fmap_buffer.sv
// Pooled feature-map buffer: captures one CH-channel pooled frame (FILL)
// then replays it channel-major, one BW word per transfer (DRAIN).
// Ports: clk, rst (sync, active-high), ce (global clock enable);
//   i_data/i_valid/i_end  pooled pixel input (all CH lanes in parallel);
//   i_ready               downstream accepts o_data;
//   o_data/o_valid/o_ch/o_end  replayed word, channel and end-of-frame;
//   o_busy                high while draining or holding a word;
//   o_err                 sticky frame error.
// Optional: define FMAP_BUF_FRAME_CHECK_EN to enable frame checking on o_err
// (otherwise o_err is tied low and i_end is ignored).
module pool_fmap_buffer
  import pool_fmap_buffer_pkg::*;
#(
  parameter int unsigned BW      = DEF_BW,
  parameter int unsigned CH      = DEF_CH,
  parameter int unsigned FM_SIZE = DEF_FM_SIZE,
  localparam int unsigned CW     = idx_w(CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [CH*BW-1:0]     i_data,
  input  logic                 i_valid,
  input  logic                 i_end,
  input  logic                 i_ready,
  output logic signed [BW-1:0] o_data,
  output logic                 o_valid,
  output logic [CW-1:0]        o_ch,
  output logic                 o_end,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int unsigned DEPTH = FM_SIZE * FM_SIZE;
  localparam int unsigned AW    = idx_w(DEPTH);

  fmap_state_e   state;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_ch;
  logic          rd_done;   // last read of the frame already issued
  logic          rd_pend;   // RAM output holds a word not yet in o_data
  logic [CW-1:0] pend_ch;
  logic          pend_end;

  logic [BW-1:0] rd_data [CH];
  logic [BW-1:0] rd_sel_c;
  logic          wr_last_c, rd_last_c, xfer_c, load_c, issue_c;

  assign wr_last_c = (wr_cnt == AW'(DEPTH - 1));
  assign rd_last_c = (rd_ch == CW'(CH - 1)) && (rd_addr == AW'(DEPTH - 1));
  assign xfer_c    = o_valid && i_ready;
  // Output register refills when empty or emptying this cycle.
  assign load_c    = rd_pend && (!o_valid || i_ready);
  // A new read may start only if the RAM output slot frees up this cycle.
  assign issue_c   = (state == DRAIN) && !rd_done && (!rd_pend || load_c);

  // One RAM per channel; all share write and read addresses.
  for (genvar c = 0; c < CH; c++) begin : g_ram
    fmap_ram #(.BW(BW), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (ce && (state == FILL) && i_valid),
      .waddr (wr_cnt),
      .wdata (i_data[c*BW +: BW]),
      .re    (ce && issue_c),
      .raddr (rd_addr),
      .rdata (rd_data[c])
    );
  end

  // Select the channel RAM that owns the pending word.
  always_comb begin
    rd_sel_c = rd_data[0];
    for (int unsigned c = 1; c < CH; c++) begin
      if (pend_ch == CW'(c)) rd_sel_c = rd_data[c];
    end
  end

  // FSM, counters and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      wr_cnt   <= '0;
      rd_addr  <= '0;
      rd_ch    <= '0;
      rd_done  <= 1'b0;
      rd_pend  <= 1'b0;
      pend_ch  <= '0;
      pend_end <= 1'b0;
      o_valid  <= 1'b0;
      o_end    <= 1'b0;
      o_data   <= '0;
      o_ch     <= '0;
    end else if (ce) begin
      case (state)
        FILL: begin
          if (i_valid) begin
            if (wr_last_c) begin
              wr_cnt <= '0;
              state  <= DRAIN;
            end else begin
              wr_cnt <= wr_cnt + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (xfer_c && o_end) state <= FILL;
        end
      endcase

      if (issue_c) begin
        pend_ch  <= rd_ch;
        pend_end <= rd_last_c;
        if (rd_addr == AW'(DEPTH - 1)) begin
          rd_addr <= '0;
          if (rd_ch == CW'(CH - 1)) rd_done <= 1'b1;
          else                      rd_ch   <= rd_ch + CW'(1);
        end else begin
          rd_addr <= rd_addr + AW'(1);
        end
      end

      // Frame fully delivered: rearm the read side for the next frame.
      if (xfer_c && o_end) begin
        rd_addr <= '0;
        rd_ch   <= '0;
        rd_done <= 1'b0;
      end

      if (issue_c)     rd_pend <= 1'b1;
      else if (load_c) rd_pend <= 1'b0;

      if (load_c) begin
        o_valid <= 1'b1;
        o_data  <= rd_sel_c;
        o_ch    <= pend_ch;
        o_end   <= pend_end;
      end else if (xfer_c) begin
        o_valid <= 1'b0;
        o_end   <= 1'b0;
      end
    end
  end

  assign o_busy = (state == DRAIN) || o_valid;

`ifdef FMAP_BUF_FRAME_CHECK_EN
  logic err_q;

  // Sticky: misplaced/missing i_end, or input offered while draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (ce && i_valid) begin
      if (state == DRAIN)            err_q <= 1'b1;
      else if (i_end != wr_last_c)   err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  logic unused_i_end;
  assign unused_i_end = i_end;
  assign o_err        = 1'b0;
`endif

endmodule

// File: doc/pool_fmap_buffer.md
POOL_FMAP_BUFFER -- requirements
Module: pool_fmap_buffer

Interface
REQ-001 Parameter BW, 16, bit width of one pooled feature value.
REQ-002 Parameter CH, 3, channels delivered in parallel by the pooling stage.
REQ-003 Parameter FM_SIZE, 12, pooled map edge; DEPTH = FM_SIZE*FM_SIZE words per channel.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 ce  in  1  clock enable; when low, all state (including outputs) holds.
REQ-007 i_data  in  CH*BW  signed pooled values; channel c occupies bits [c*BW +: BW].
REQ-008 i_valid  in  1  i_data is a valid pooled pixel.
REQ-009 i_end  in  1  marks the final pooled pixel of a frame; qualified by i_valid.
REQ-010 i_ready  in  1  downstream conv stage accepts o_data this cycle.
REQ-011 o_data  out  BW  signed replayed value.
REQ-012 o_valid  out  1  o_data is valid.
REQ-013 o_ch  out  clog2(CH)  channel index of o_data.
REQ-014 o_end  out  1  high with the last word of the last channel.
REQ-015 o_busy  out  1  high outside FILL.
REQ-016 o_err  out  1  sticky frame-error flag.

Function
REQ-017 The FSM SHALL have the states FILL and DRAIN, with FILL as the reset state.
REQ-018 In FILL, each ce&i_valid cycle SHALL write all CH lanes at address wr_cnt into CH BW-wide memories and increment wr_cnt.
REQ-019 The write with wr_cnt==DEPTH-1 SHALL move the FSM to DRAIN next cycle and clear wr_cnt.
REQ-020 In DRAIN, i_valid SHALL be ignored: no write occurs and no counter advances.
REQ-021 Drain order SHALL be channel-major: channel 0 addresses 0..DEPTH-1, then channel 1, and so on.
REQ-022 Memory reads SHALL be synchronous with 1-cycle latency, followed by a one-entry output register (depth 2 total including the in-flight read) so that no word is lost or duplicated under backpressure.
REQ-023 A transfer SHALL occur on ce&o_valid&i_ready; o_data, o_ch and o_end SHALL stay stable while o_valid&!i_ready.
REQ-024 With i_ready held high, o_valid SHALL first rise 2 cycles after the final write and then stay high for CH*DEPTH consecutive cycles.
REQ-025 o_end SHALL be high only with the word (ch CH-1, addr DEPTH-1); after that transfer the FSM SHALL return to FILL and clear all read counters.
REQ-026 i_valid in the cycle the FSM returns to FILL SHALL be written at address 0.
REQ-027 Data SHALL pass through unmodified, with no arithmetic, saturation or sign change.
REQ-028 o_busy SHALL equal (state==DRAIN) | o_valid.

Reset
REQ-029 rst SHALL force state FILL, clear every counter, clear o_valid, o_end and o_err, and set o_data and o_ch to 0; rst takes priority over ce.
REQ-030 Reset mid-DRAIN SHALL discard the frame; memory contents need not be cleared.

Configuration
REQ-031 FMAP_BUF_FRAME_CHECK_EN defined: o_err SHALL set, and stay set until rst, in any of these cases: i_end with wr_cnt!=DEPTH-1, no i_end on the DEPTH-th write, or i_valid during DRAIN. The frame still completes normally.
REQ-032 FMAP_BUF_FRAME_CHECK_EN undefined: o_err SHALL be tied 0, i_end ignored, and no checking logic synthesised.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the default BW, CH and FM_SIZE constants, shared with the conv layers.
REQ-034 One sub-module, fmap_ram (single-write/single-read synchronous RAM, BW x DEPTH), SHALL be instantiated CH times.

Verification
REQ-035 Ramp fill: write 144 pixels with lane c = 1000*c+k and i_ready=1 -> 432 words out in the order 0..143, 1000..1143, 2000..2143; o_end only on 2143.
REQ-036 Backpressure: toggle i_ready pseudo-randomly during drain -> identical sequence, no gaps or duplicates, and outputs stable while stalled.
REQ-037 ce low for 5 cycles mid-fill and mid-drain -> no state change; final output unchanged from REQ-035.
REQ-038 rst at drain word 200 -> o_valid=0 next cycle, state FILL; a new 144-pixel frame drains correctly from 0.
REQ-039 With the macro defined: i_end on pixel 100 -> o_err=1, held; i_valid during DRAIN -> o_err=1. Without the macro -> o_err stays 0.
REQ-040 Back-to-back frames: i_valid asserted in the cycle after o_end -> that pixel is stored at address 0 of the next frame.
